// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and Gray-code helpers shared by the write- and
// read-pointer handlers of the asynchronous FIFO.
//   FIFO_DEPTH      default number of FIFO entries (power of two)
//   FIFO_PTR_WIDTH  default log2(FIFO_DEPTH); pointers carry one extra wrap bit
//   PTR_MAX_W       widest pointer the helpers handle; callers zero-extend
//                   into it and slice the low bits back out
package fifo_pkg;

  localparam int FIFO_DEPTH     = 8;
  localparam int FIFO_PTR_WIDTH = 3;
  localparam int PTR_MAX_W      = 16;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros in a zero-extended Gray value decode to leading zeros,
  // so the wide conversion is exact for any narrower pointer.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_handler_if.sv
// fifo_wptr_handler_if: producer-side bundle of the FIFO write-pointer handler.
//   w_en, ovf_clr, g_rptr            driven by the producer / read domain
//   b_wptr, g_wptr, full, almost_full,
//   wr_level, wr_ack, overflow       driven by the write-pointer handler
// Modports: master = producer side, slave = fifo_wptr_handler.
interface fifo_wptr_handler_if #(
  parameter int PTR_WIDTH = 3
);
  logic                 w_en;
  logic                 ovf_clr;
  logic [PTR_WIDTH:0]   g_rptr;
  logic [PTR_WIDTH:0]   b_wptr;
  logic [PTR_WIDTH:0]   g_wptr;
  logic                 full;
  logic                 almost_full;
  logic [PTR_WIDTH:0]   wr_level;
  logic                 wr_ack;
  logic                 overflow;

  modport master (
    output w_en, ovf_clr, g_rptr,
    input  b_wptr, g_wptr, full, almost_full, wr_level, wr_ack, overflow
  );

  modport slave (
    input  w_en, ovf_clr, g_rptr,
    output b_wptr, g_wptr, full, almost_full, wr_level, wr_ack, overflow
  );
endinterface

// File: rtl/ptr_sync.sv
// ptr_sync: two-flop synchronizer for a Gray-coded pointer crossing into
// the clk domain. Only one bit changes per pointer step, so a sampled value
// is always either the old or the new pointer.
//   clk  destination clock
//   rst  asynchronous active-high reset, clears both stages
//   d    pointer from the foreign clock domain
//   q    synchronized pointer (two clk edges of latency)
module ptr_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_wptr_handler.sv
// fifo_wptr_handler: write-side pointer logic of an asynchronous FIFO.
// Keeps binary and Gray write pointers, synchronizes the read pointer,
// and produces registered full / almost_full / level / ack / overflow.
// Ports:
//   wclk  write-domain clock (only clock of the block)
//   wrst  asynchronous active-high reset
//   wif   fifo_wptr_handler_if.slave: w_en, ovf_clr, g_rptr in;
//         b_wptr, g_wptr, full, almost_full, wr_level, wr_ack, overflow out
// Configuration macro: FIFO_WPTR_ALMOST_FULL_EN builds the almost_full
// comparator (level >= AF_THRESH); without it almost_full is tied to 0.
module fifo_wptr_handler
  import fifo_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int PTR_WIDTH = FIFO_PTR_WIDTH,
  parameter int AF_THRESH = 6
) (
  input  logic               wclk,
  input  logic               wrst,
  fifo_wptr_handler_if.slave wif
);

  if (DEPTH != (1 << PTR_WIDTH) || AF_THRESH < 1 || AF_THRESH > DEPTH - 1
      || PTR_WIDTH < 2 || PTR_WIDTH + 1 > PTR_MAX_W) begin : g_param_check
    $error("fifo_wptr_handler: inconsistent DEPTH/PTR_WIDTH/AF_THRESH");
  end

  logic [PTR_WIDTH:0]   g_rptr_sync;
  logic [PTR_WIDTH:0]   rptr_w;
  logic [PTR_WIDTH:0]   g_rptr_full;
  logic [PTR_WIDTH:0]   b_wptr_next;
  logic [PTR_WIDTH:0]   g_wptr_next;
  logic [PTR_WIDTH:0]   level_next;
  logic [PTR_MAX_W-1:0] rptr_wide;
  logic [PTR_MAX_W-1:0] gwptr_wide;
  logic                 accept;
  logic                 full_next;
  logic                 af_next;

  ptr_sync #(.WIDTH(PTR_WIDTH + 1)) u_rptr_sync (
    .clk (wclk),
    .rst (wrst),
    .d   (wif.g_rptr),
    .q   (g_rptr_sync)
  );

  always_comb begin
    accept      = wif.w_en & ~wif.full;
    b_wptr_next = wif.b_wptr + {{PTR_WIDTH{1'b0}}, accept};
    gwptr_wide  = bin2gray(PTR_MAX_W'(b_wptr_next));
    g_wptr_next = gwptr_wide[PTR_WIDTH:0];
    rptr_wide   = gray2bin(PTR_MAX_W'(g_rptr_sync));
    rptr_w      = rptr_wide[PTR_WIDTH:0];
    // In Gray code, "DEPTH ahead of the read pointer" means the two MSBs
    // are inverted and the remaining bits match.
    g_rptr_full = {~g_rptr_sync[PTR_WIDTH -: 2], g_rptr_sync[PTR_WIDTH-2:0]};
    full_next   = (g_wptr_next == g_rptr_full);
    // Modular subtraction makes pointer wrap-around transparent.
    level_next  = b_wptr_next - rptr_w;
`ifdef FIFO_WPTR_ALMOST_FULL_EN
    af_next     = (level_next >= (PTR_WIDTH + 1)'(AF_THRESH));
`else
    af_next     = 1'b0;
`endif
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wif.b_wptr      <= '0;
      wif.g_wptr      <= '0;
      wif.full        <= 1'b0;
      wif.almost_full <= 1'b0;
      wif.wr_level    <= '0;
      wif.wr_ack      <= 1'b0;
      wif.overflow    <= 1'b0;
    end else begin
      wif.b_wptr      <= b_wptr_next;
      wif.g_wptr      <= g_wptr_next;
      wif.full        <= full_next;
      wif.almost_full <= af_next;
      wif.wr_level    <= level_next;
      wif.wr_ack      <= accept;
      // A write attempt while full outranks a clear in the same cycle.
      if (wif.w_en && wif.full) begin
        wif.overflow <= 1'b1;
      end else if (wif.ovf_clr) begin
        wif.overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wptr_handler.sv
// tb_fifo_wptr_handler: bench for fifo_wptr_handler (DEPTH=8, AF_THRESH=6).
// Directed vector table, hand-written reset sequences, and a randomized
// stream checked against a count-based model of the write side.
module tb_fifo_wptr_handler;
  import fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = 3;
  localparam int AFT   = 6;
  localparam int PMOD  = 16;
`ifdef FIFO_WPTR_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic wclk = 1'b0;
  logic wrst;
  always #5 wclk = ~wclk;

  fifo_wptr_handler_if #(.PTR_WIDTH(PW)) wif ();

  fifo_wptr_handler #(.DEPTH(DEPTH), .PTR_WIDTH(PW), .AF_THRESH(AFT)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .wif  (wif)
  );

  int checks = 0;
  int passed = 0;

  typedef struct {
    int w_en; int clr; int rd;
    int b; int f; int lvl; int ack; int ovf;
  } vec_t;
  vec_t vecs[$];

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_outputs(input string tag, input int b, input int f,
                               input int lvl, input int ack, input int ovf);
    chk({tag, " b_wptr"},      int'(wif.b_wptr),      b);
    chk({tag, " g_wptr"},      int'(wif.g_wptr),      gray_of(b));
    chk({tag, " full"},        int'(wif.full),        f);
    chk({tag, " wr_level"},    int'(wif.wr_level),    lvl);
    chk({tag, " almost_full"}, int'(wif.almost_full), (AF_EN && lvl >= AFT) ? 1 : 0);
    chk({tag, " wr_ack"},      int'(wif.wr_ack),      ack);
    chk({tag, " overflow"},    int'(wif.overflow),    ovf);
  endtask

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  // Reset with a write request pending; that request must be discarded.
  task automatic do_reset;
    wif.w_en    = 1'b1;
    wif.ovf_clr = 1'b0;
    wif.g_rptr  = '0;
    wrst        = 1'b1;
    repeat (2) tick;
    check_outputs("reset", 0, 0, 0, 0, 0);
    wif.w_en = 1'b0;
    wrst     = 1'b0;
  endtask

  function automatic void add(input int w, input int c, input int rd, input int b,
                              input int f, input int lvl, input int ack, input int ovf);
    vecs.push_back('{w, c, rd, b, f, lvl, ack, ovf});
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got no summary, expected completion");
    $fatal(1);
  end

  initial begin
    // ---------------- directed table ----------------
    for (int i = 0; i < 8; i++) add(1, 0, 0, i + 1, (i == 7) ? 1 : 0, i + 1, 1, 0);
    add(1, 0, 0, 8, 1, 8, 0, 1);
    add(1, 0, 0, 8, 1, 8, 0, 1);
    add(0, 0, 0, 8, 1, 8, 0, 1);
    add(1, 1, 0, 8, 1, 8, 0, 1);   // clear loses to a simultaneous set
    add(0, 1, 0, 8, 1, 8, 0, 0);
    add(0, 0, 1, 8, 1, 8, 0, 0);   // read pointer moves: 3 edges to be seen
    add(0, 0, 1, 8, 1, 8, 0, 0);
    add(0, 0, 1, 8, 0, 7, 0, 0);
    add(1, 0, 1, 9, 1, 8, 1, 0);
    add(0, 0, 1, 9, 1, 8, 0, 0);
    add(0, 0, 4, 9, 1, 8, 0, 0);
    add(0, 0, 4, 9, 1, 8, 0, 0);
    add(0, 0, 4, 9, 0, 5, 0, 0);
    add(1, 0, 4, 10, 0, 6, 1, 0);  // level 5 -> 6
    add(0, 0, 5, 10, 0, 6, 0, 0);
    add(0, 0, 5, 10, 0, 6, 0, 0);
    add(0, 0, 5, 10, 0, 5, 0, 0);  // level 6 -> 5

    wrst = 1'b1;
    wif.w_en = 1'b0; wif.ovf_clr = 1'b0; wif.g_rptr = '0;
    #2;
    check_outputs("async_reset0", 0, 0, 0, 0, 0);
    do_reset;

    foreach (vecs[i]) begin
      wif.w_en    = vecs[i].w_en[0];
      wif.ovf_clr = vecs[i].clr[0];
      wif.g_rptr  = (PW + 1)'(gray_of(vecs[i].rd));
      tick;
      check_outputs($sformatf("vec%0d", i), vecs[i].b, vecs[i].f, vecs[i].lvl,
                    vecs[i].ack, vecs[i].ovf);
    end

    // ---------------- reset mid-stream at level 5 ----------------
    do_reset;
    wif.w_en = 1'b1;
    repeat (5) tick;
    check_outputs("pre_reset", 5, 0, 5, 1, 0);
    wrst = 1'b1;
    #2;
    check_outputs("midstream_reset", 0, 0, 0, 0, 0);
    tick;
    check_outputs("reset_held", 0, 0, 0, 0, 0);
    wrst = 1'b0;
    tick;
    check_outputs("first_after_reset", 1, 0, 1, 1, 0);
    wif.w_en = 1'b0;

    // ---------------- randomized stream vs. model ----------------
    begin
      int wr = 0, rd = 0, cyc = 0, seen, lvl, acc, prev_g = 0, g;
      int full_m = 0, ovf_m = 0, we, clr;
      int hist[$];
      do_reset;
      while (wr < 40 && cyc < 3000) begin
        we  = ($urandom_range(3) != 0) ? 1 : 0;
        clr = ($urandom_range(7) == 0) ? 1 : 0;
        if (rd < wr && $urandom_range(2) == 0) rd++;
        wif.w_en    = we[0];
        wif.ovf_clr = clr[0];
        wif.g_rptr  = (PW + 1)'(gray_of(rd % PMOD));
        // The write side sees the read count that was driven two cycles ago.
        hist.push_back(rd);
        seen = (hist.size() >= 3) ? hist[hist.size() - 3] : 0;
        acc  = (we != 0 && full_m == 0) ? 1 : 0;
        if (we != 0 && full_m != 0) ovf_m = 1;
        else if (clr != 0) ovf_m = 0;
        wr    += acc;
        lvl    = wr - seen;
        full_m = (lvl == DEPTH) ? 1 : 0;
        tick;
        check_outputs("rand", wr % PMOD, full_m, lvl, acc, ovf_m);
        g = int'(wif.g_wptr);
        chk("rand gray_step_bits", $countones(g ^ prev_g), acc);
        prev_g = g;
        cyc++;
      end
      if (wr < 40) chk("rand write_budget", wr, 40);
      wif.w_en = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
